irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller between the peripheral sources and the CPU `HWInt[7:2]` inputs.
- Synchronises six raw device interrupt lines and detects edges or levels per source.
- Holds pending and mask state, and drives a registered `HWInt` vector.
- The CPU accesses it through the bridge as a 5-word register window: `Addr[4:2]` plus a decoded write enable.

Parameters:
- `RESET_MASK`, 6'h3F, MASK register value after reset (1 = enabled).
- `RESET_MODE`, 6'h00, MODE register value after reset (1 = edge, 0 = level).

Ports:
- `clk` input 1: system clock, all state on its rising edge.
- `reset` input 1: asynchronous, active-high; clears or initialises all state immediately.
- `irq_in` input 6: raw asynchronous device interrupt lines; bit i maps to `HWInt[i+2]`.
- `Addr` input 3: word offset, `Addr[4:2]` of the CPU address.
- `We` input 1: register write strobe, already decoded by the bridge for this window.
- `WD` input 32: write data.
- `RD` output 32: read data, combinational from `Addr`.
- `HWInt` output 6 (`[7:2]`): registered masked-pending vector to the CPU.
- `irq_any` output 1: registered OR of `HWInt`.

Behaviour:
- Reset values:
  - sync stages s1, s2, s3 = 0; PEND = 0; `HWInt` = 0; `irq_any` = 0.
  - MASK = `RESET_MASK`; MODE = `RESET_MODE`.
- Synchroniser and edge detect:
  - s1 <= `irq_in`; s2 <= s1; s3 <= s2.
  - rise = s2 & ~s3.
- PEND update, per bit i, each cycle:
  - Level mode (MODE[i]=0): PEND[i] <= s2[i]. CLR writes have no effect on this bit.
  - Edge mode (MODE[i]=1): PEND[i] <= rise[i] | (PEND[i] & ~clr[i]), where clr = `WD[5:0]` when `We` and `Addr`=3, else 0. A set in the same cycle as a clear wins.
  - Writing MODE does not alter PEND. A bit switched from level to edge keeps its current value until cleared.
- Outputs:
  - `HWInt` <= PEND_next & MASK_next, i.e. `HWInt` reflects the same-edge update, one register stage.
  - `irq_any` <= |(PEND_next & MASK_next).
- Latency: `irq_in[i]` rising with setup before edge E0 gives PEND[i] set after edge E2 and `HWInt[i+2]` high after edge E2. Total is 3 clock edges.
- Register map (`Addr`):
  - 0 PEND: RO, read = {26'b0, PEND}. Writes ignored.
  - 1 MASK: RW, writes `WD[5:0]`. Takes effect on `HWInt` the same edge.
  - 2 MODE: RW, writes `WD[5:0]`.
  - 3 CLR: WO, write-1-to-clear edge-mode bits. Read = 0.
  - 4 CUR: RO, read = index (0..5) of the lowest-numbered set bit of PEND & MASK, in bits [2:0], with bit 31 = 0. If none is set, read = 32'hFFFF_FFFF. Source 0 is highest priority.
  - 5..7: read 0, writes ignored.
- `RD` decodes the current register state (pre-edge); a read in the same cycle as a write returns the old value.
- Boundary cases:
  - Reset asserted mid-operation clears PEND and `HWInt` asynchronously, with no glitch past the reset value. The first pending can occur 3 edges after reset release, if the line is held high.
  - A pulse shorter than one clock may be missed. This is allowed; devices must hold lines ≥ 1 cycle.
  - An edge-mode line held high produces exactly one PEND set. Clearing while still high does not re-set.
  - Masked pending bits remain in PEND and appear on `HWInt` immediately when unmasked.

Test Plan:
- Reset with defaults, `irq_in`=6'b000100 held → `HWInt` = 6'b000100 after 3rd edge, `RD`@`Addr`4 = 2, `irq_any`=1; drop input → `HWInt`=0 3 edges later (level mode).
- Write MODE=6'h3F, pulse `irq_in[5]` 2 cycles → PEND=6'h20 held after pulse; write CLR=6'h20 → PEND=0, `HWInt[7]`=0 next edge.
- Edge mode, rise detected on the same edge as CLR write of that bit → PEND bit stays 1.
- MASK=6'h00, assert `irq_in`=6'h09 → PEND=6'h09, `HWInt`=0, CUR=32'hFFFF_FFFF; write MASK=6'h08 → `HWInt`=6'h08 same edge, CUR=3.
- Assert reset asynchronously between edges with PEND=6'h3F → `HWInt`, PEND=0 immediately, MASK returns to 6'h3F.
- Write `Addr`=0 and `Addr`=6 with 32'hFFFF_FFFF → no state change; `RD`@6 = 0.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: register-window bus between the CPU bridge and the interrupt
// controller.
//   Addr : word offset (CPU address bits [4:2])
//   We   : write strobe, already decoded for this window
//   WD   : write data
//   RD   : read data, combinational from Addr
// The master modport is the bridge side; the slave modport is the controller.
interface irq_ctrl_if;
  logic [2:0]  Addr;
  logic        We;
  logic [31:0] WD;
  logic [31:0] RD;

  modport master (output Addr, We, WD, input RD);
  modport slave  (input Addr, We, WD, output RD);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller feeding the CPU HWInt[7:2]
// inputs. It synchronises six raw device lines, captures them per source as
// level or rising edge, and drives a registered masked-pending vector.
// Ports:
//   clk     : system clock, all state on its rising edge
//   reset   : asynchronous, active-high
//   irq_in  : raw device lines, bit i maps to HWInt[i+2]
//   bus     : register window (Addr/We/WD in, RD out)
//   HWInt   : registered PEND & MASK
//   irq_any : registered OR of HWInt
// Register map: 0 PEND (RO), 1 MASK (RW), 2 MODE (RW, 1 = edge),
// 3 CLR (WO, write-1-to-clear edge bits), 4 CUR (RO, lowest active index or
// all ones), 5..7 read zero.
module irq_ctrl #(
  parameter logic [5:0] RESET_MASK = 6'h3F,
  parameter logic [5:0] RESET_MODE = 6'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       irq_in,
  irq_ctrl_if.slave        bus,
  output logic [7:2]       HWInt,
  output logic             irq_any
);

  typedef enum logic [2:0] {
    REG_PEND = 3'd0,
    REG_MASK = 3'd1,
    REG_MODE = 3'd2,
    REG_CLR  = 3'd3,
    REG_CUR  = 3'd4
  } regAddr_e;

  logic [5:0] s1, s2, s3;
  logic [5:0] pend, mask, mode;

  logic [5:0] rise, clr;
  logic [5:0] pendNext, maskNext, modeNext, active;
  logic [2:0] curIdx;
  logic       curValid;

  // Upper write-data bits carry nothing for this block.
  logic unusedBits;
  assign unusedBits = ^bus.WD[31:6];

  // Next-state decode. Mask and mode writes feed the output stage on the
  // same edge, so HWInt sees a mask change without an extra cycle.
  // NOTE: every always_comb output gets a value on every path (defaults or
  // a full if/else); a missing branch would infer a latch.
  always_comb begin
    rise     = s2 & ~s3;
    clr      = (bus.We && bus.Addr == REG_CLR)  ? bus.WD[5:0] : 6'h00;
    maskNext = (bus.We && bus.Addr == REG_MASK) ? bus.WD[5:0] : mask;
    modeNext = (bus.We && bus.Addr == REG_MODE) ? bus.WD[5:0] : mode;
    for (int i = 0; i < 6; i++) begin
      // Edge sources latch a rise until cleared (a rise beats a clear);
      // level sources simply follow the synchronised line.
      if (mode[i]) pendNext[i] = rise[i] | (pend[i] & ~clr[i]);
      else         pendNext[i] = s2[i];
    end
  end

  // Lowest-numbered active source has priority; scan high to low so the
  // last hit is the winner.
  always_comb begin
    active   = pend & mask;
    curIdx   = 3'd0;
    curValid = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (active[i]) begin
        curIdx   = 3'(i);
        curValid = 1'b1;
      end
    end
  end

  // Read mux reflects the pre-edge register state.
  always_comb begin
    bus.RD = 32'h0;
    case (bus.Addr)
      REG_PEND: bus.RD = {26'b0, pend};
      REG_MASK: bus.RD = {26'b0, mask};
      REG_MODE: bus.RD = {26'b0, mode};
      REG_CUR:  bus.RD = curValid ? {29'b0, curIdx} : 32'hFFFF_FFFF;
      default:  bus.RD = 32'h0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would collapse the synchroniser.
  // NOTE: the synchroniser flops are reset along with the rest so that no
  // stale edge is seen right after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= 6'h00;
      s2      <= 6'h00;
      s3      <= 6'h00;
      pend    <= 6'h00;
      mask    <= RESET_MASK;
      mode    <= RESET_MODE;
      HWInt   <= 6'h00;
      irq_any <= 1'b0;
    end else begin
      s1      <= irq_in;
      s2      <= s1;
      s3      <= s2;
      pend    <= pendNext;
      mask    <= maskNext;
      mode    <= modeNext;
      HWInt   <= pendNext & maskNext;
      irq_any <= |(pendNext & maskNext);
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl. Inputs change and outputs are sampled around
// the falling edge; the DUT acts on the rising edge.
module tb_irq_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] irq_in;
  logic [7:2] HWInt;
  logic       irq_any;

  int passCount  = 0;
  int checkCount = 0;

  irq_ctrl_if busIf ();

  irq_ctrl #(.RESET_MASK(6'h3F), .RESET_MODE(6'h00)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .bus     (busIf),
    .HWInt   (HWInt),
    .irq_any (irq_any)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Combinational register read.
  task automatic peek(input logic [2:0] a, output logic [31:0] d);
    busIf.Addr = a;
    #1;
    d = busIf.RD;
  endtask

  // One-cycle register write, launched just after a falling edge.
  task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
    busIf.We   = 1'b1;
    busIf.Addr = a;
    busIf.WD   = d;
    @(negedge clk);
    busIf.We   = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (2) @(negedge clk);
    checkCount++;
    if (HWInt !== 6'h00) $display("FAIL reset_hwint got %h want 00", HWInt); else passCount++;
    checkCount++;
    if (irq_any !== 1'b0) $display("FAIL reset_irq_any got %b want 0", irq_any); else passCount++;
    peek(3'd0, d);
    checkCount++;
    if (d !== 32'h0) $display("FAIL reset_pend got %h want 0", d); else passCount++;
    peek(3'd1, d);
    checkCount++;
    if (d !== 32'h3F) $display("FAIL reset_mask got %h want 3f", d); else passCount++;
    peek(3'd2, d);
    checkCount++;
    if (d !== 32'h0) $display("FAIL reset_mode got %h want 0", d); else passCount++;
    peek(3'd4, d);
    checkCount++;
    if (d !== 32'hFFFF_FFFF) $display("FAIL reset_cur got %h want ffffffff", d); else passCount++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_level();
    logic [31:0] d;
    irq_in = 6'b000100;
    repeat (2) @(negedge clk);
    checkCount++;
    if (HWInt !== 6'h00) $display("FAIL level_early got %h want 00", HWInt); else passCount++;
    @(negedge clk);
    checkCount++;
    if (HWInt !== 6'b000100) $display("FAIL level_hwint got %h want 04", HWInt); else passCount++;
    checkCount++;
    if (irq_any !== 1'b1) $display("FAIL level_irq_any got %b want 1", irq_any); else passCount++;
    peek(3'd4, d);
    checkCount++;
    if (d !== 32'd2) $display("FAIL level_cur got %h want 2", d); else passCount++;
    irq_in = 6'h00;
    repeat (2) @(negedge clk);
    checkCount++;
    if (HWInt !== 6'b000100) $display("FAIL level_hold got %h want 04", HWInt); else passCount++;
    @(negedge clk);
    checkCount++;
    if (HWInt !== 6'h00) $display("FAIL level_drop got %h want 00", HWInt); else passCount++;
    checkCount++;
    if (irq_any !== 1'b0) $display("FAIL level_drop_any got %b want 0", irq_any); else passCount++;
  endtask

  task automatic test_edge();
    logic [31:0] d;
    writeReg(3'd2, 32'h3F);
    peek(3'd2, d);
    checkCount++;
    if (d !== 32'h3F) $display("FAIL edge_mode_rd got %h want 3f", d); else passCount++;
    irq_in = 6'h20;
    repeat (2) @(negedge clk);
    irq_in = 6'h00;
    repeat (4) @(negedge clk);
    peek(3'd0, d);
    checkCount++;
    if (d !== 32'h20) $display("FAIL edge_pend_held got %h want 20", d); else passCount++;
    checkCount++;
    if (HWInt !== 6'h20) $display("FAIL edge_hwint got %h want 20", HWInt); else passCount++;
    writeReg(3'd3, 32'h20);
    peek(3'd0, d);
    checkCount++;
    if (d !== 32'h0) $display("FAIL edge_clr_pend got %h want 0", d); else passCount++;
    checkCount++;
    if (HWInt !== 6'h00) $display("FAIL edge_clr_hwint got %h want 00", HWInt); else passCount++;
  endtask

  task automatic test_clr_collision();
    logic [31:0] d;
    irq_in = 6'h01;
    repeat (2) @(negedge clk);
    // Rise reaches the pending logic on this edge, together with the clear.
    writeReg(3'd3, 32'h01);
    peek(3'd0, d);
    checkCount++;
    if (d !== 32'h01) $display("FAIL collision_set_wins got %h want 1", d); else passCount++;
    writeReg(3'd3, 32'h01);
    peek(3'd0, d);
    checkCount++;
    if (d !== 32'h0) $display("FAIL held_clear got %h want 0", d); else passCount++;
    repeat (3) @(negedge clk);
    peek(3'd0, d);
    checkCount++;
    if (d !== 32'h0) $display("FAIL held_no_reset got %h want 0", d); else passCount++;
    irq_in = 6'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mask();
    logic [31:0] d;
    writeReg(3'd2, 32'h00);
    writeReg(3'd1, 32'h00);
    irq_in = 6'h09;
    repeat (3) @(negedge clk);
    peek(3'd0, d);
    checkCount++;
    if (d !== 32'h09) $display("FAIL mask_pend got %h want 9", d); else passCount++;
    checkCount++;
    if (HWInt !== 6'h00) $display("FAIL mask_hwint got %h want 00", HWInt); else passCount++;
    checkCount++;
    if (irq_any !== 1'b0) $display("FAIL mask_any got %b want 0", irq_any); else passCount++;
    peek(3'd4, d);
    checkCount++;
    if (d !== 32'hFFFF_FFFF) $display("FAIL mask_cur_none got %h want ffffffff", d); else passCount++;
    busIf.We   = 1'b1;
    busIf.Addr = 3'd1;
    busIf.WD   = 32'h08;
    #1;
    checkCount++;
    if (busIf.RD !== 32'h0) $display("FAIL read_during_write got %h want 0", busIf.RD); else passCount++;
    @(negedge clk);
    busIf.We = 1'b0;
    checkCount++;
    if (HWInt !== 6'h08) $display("FAIL unmask_hwint got %h want 08", HWInt); else passCount++;
    checkCount++;
    if (irq_any !== 1'b1) $display("FAIL unmask_any got %b want 1", irq_any); else passCount++;
    peek(3'd4, d);
    checkCount++;
    if (d !== 32'd3) $display("FAIL unmask_cur got %h want 3", d); else passCount++;
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    writeReg(3'd1, 32'h3F);
    irq_in = 6'h3F;
    repeat (3) @(negedge clk);
    checkCount++;
    if (HWInt !== 6'h3F) $display("FAIL all_hwint got %h want 3f", HWInt); else passCount++;
    peek(3'd4, d);
    checkCount++;
    if (d !== 32'd0) $display("FAIL all_cur got %h want 0", d); else passCount++;
    writeReg(3'd1, 32'h15);
    checkCount++;
    if (HWInt !== 6'h15) $display("FAIL remask_hwint got %h want 15", HWInt); else passCount++;
    #3;
    reset = 1'b1;
    #1;
    checkCount++;
    if (HWInt !== 6'h00) $display("FAIL async_hwint got %h want 00", HWInt); else passCount++;
    checkCount++;
    if (irq_any !== 1'b0) $display("FAIL async_any got %b want 0", irq_any); else passCount++;
    peek(3'd0, d);
    checkCount++;
    if (d !== 32'h0) $display("FAIL async_pend got %h want 0", d); else passCount++;
    peek(3'd1, d);
    checkCount++;
    if (d !== 32'h3F) $display("FAIL async_mask got %h want 3f", d); else passCount++;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkCount++;
    if (HWInt !== 6'h00) $display("FAIL post_reset_early got %h want 00", HWInt); else passCount++;
    @(negedge clk);
    checkCount++;
    if (HWInt !== 6'h3F) $display("FAIL post_reset_first got %h want 3f", HWInt); else passCount++;
    irq_in = 6'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_ignored_writes();
    logic [31:0] d;
    writeReg(3'd0, 32'hFFFF_FFFF);
    writeReg(3'd5, 32'hFFFF_FFFF);
    writeReg(3'd6, 32'hFFFF_FFFF);
    writeReg(3'd7, 32'hFFFF_FFFF);
    peek(3'd0, d);
    checkCount++;
    if (d !== 32'h0) $display("FAIL ign_pend got %h want 0", d); else passCount++;
    peek(3'd1, d);
    checkCount++;
    if (d !== 32'h3F) $display("FAIL ign_mask got %h want 3f", d); else passCount++;
    peek(3'd2, d);
    checkCount++;
    if (d !== 32'h0) $display("FAIL ign_mode got %h want 0", d); else passCount++;
    peek(3'd6, d);
    checkCount++;
    if (d !== 32'h0) $display("FAIL ign_rd6 got %h want 0", d); else passCount++;
    checkCount++;
    if (HWInt !== 6'h00) $display("FAIL ign_hwint got %h want 00", HWInt); else passCount++;
    // Clearing has no effect on level-mode sources.
    irq_in = 6'h02;
    repeat (3) @(negedge clk);
    writeReg(3'd3, 32'h3F);
    peek(3'd0, d);
    checkCount++;
    if (d !== 32'h02) $display("FAIL level_clr_pend got %h want 2", d); else passCount++;
    peek(3'd3, d);
    checkCount++;
    if (d !== 32'h0) $display("FAIL clr_read got %h want 0", d); else passCount++;
    checkCount++;
    if (HWInt !== 6'h02) $display("FAIL level_clr_hwint got %h want 02", HWInt); else passCount++;
  endtask

  initial begin
    reset      = 1'b1;
    irq_in     = 6'h00;
    busIf.We   = 1'b0;
    busIf.Addr = 3'd0;
    busIf.WD   = 32'h0;
    test_reset();
    test_level();
    test_edge();
    test_clr_collision();
    test_mask();
    test_async_reset();
    test_ignored_writes();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
